// File: rtl/ofd_pipe.sv
// Parametrised pad-boundary output register pipeline with per-word valid,
// synchronous flush, optional hold-last-valid output and a wrapping transfer counter.
module ofd_pipe #(
  parameter int unsigned      WIDTH = 5,
  parameter int unsigned      DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int unsigned      HOLD  = 0,
  parameter int unsigned      CNTW  = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             CE,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic [CNTW-1:0]  CNT,
  output logic             OVF
);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_r;
    logic             v_in;
    logic             v_r;

    if (k == 0) begin : g_first
      assign d_in = D;
      assign v_in = DV;
    end else begin : g_next
      assign d_in = g_stage[k-1].d_r;
      assign v_in = g_stage[k-1].v_r;
    end

    if (k == DEPTH - 1) begin : g_out
      logic [CNTW-1:0] cnt_r;
      logic            ovf_r;

      // The counter lives with the output stage so it advances on the
      // same edge that raises QV for the counted word.
      always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
          d_r   <= INIT;
          v_r   <= 1'b0;
          cnt_r <= '0;
          ovf_r <= 1'b0;
        end else if (CLR) begin
          d_r   <= INIT;
          v_r   <= 1'b0;
          cnt_r <= '0;
          ovf_r <= 1'b0;
        end else if (CE) begin
          v_r <= v_in;
          if (HOLD == 0 || v_in) begin
            d_r <= d_in;
          end
          if (v_in) begin
            cnt_r <= cnt_r + 1'b1;
            if (cnt_r == '1) begin
              ovf_r <= 1'b1;
            end
          end
        end
      end

      assign Q   = d_r;
      assign QV  = v_r;
      assign CNT = cnt_r;
      assign OVF = ovf_r;
    end else begin : g_mid
      always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
          d_r <= INIT;
          v_r <= 1'b0;
        end else if (CLR) begin
          d_r <= INIT;
          v_r <= 1'b0;
        end else if (CE) begin
          d_r <= d_in;
          v_r <= v_in;
        end
      end
    end
  end

endmodule
